apb_gpio_irq_ctrl: RTL and testbench
====================================

# apb_gpio_irq_ctrl

APB master controller that sits in front of the GPIO peripheral's APB slave port. It shares that port between a register-configuration requester and an internal interrupt service sequencer. When the GPIO interrupt is raised, the sequencer reads the GPIO status register, which clears the interrupt. It then streams each flagged pin index out as a separate event, lowest index first, on a valid/ready interface toward the event unit.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and cfg_addr
- STATUS_ADDR, 'h018, GPIO interrupt-status register offset; reading it clears the GPIO interrupt

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- irq_i  in  1  GPIO interrupt line (level)
- cfg_req  in  1  config transfer request; hold high, with fields stable, until cfg_done
- cfg_addr  in  APB_ADDR_WIDTH  config transfer address
- cfg_wdata  in  32  config write data
- cfg_write  in  1  1 = write, 0 = read
- cfg_done  out  1  config transfer completes this cycle
- cfg_rdata  out  32  read data, valid with cfg_done
- cfg_err  out  1  PSLVERR of transfer, valid with cfg_done
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error
- evt_valid  out  1  pin event available
- evt_pin  out  5  pin index of event
- evt_ready  in  1  event consumer accepts
- status_err  out  1  one-cycle pulse: status read returned PSLVERR
- busy  out  1  APB FSM not IDLE or events pending

## Operation
- FSM states:
  - IDLE: PSEL=0.
  - SETUP: PSEL=1, PENABLE=0; PADDR/PWDATA/PWRITE registered from the winning owner.
  - ACCESS: PSEL=1, PENABLE=1; held until PREADY=1, then back to IDLE. No back-to-back transfer without an IDLE cycle.
- Requesters in IDLE:
  - irq_req = irq_i && (pending==0).
  - cfg_req.
- Arbitration, decided in IDLE only:
  - If exactly one requester is active, it wins.
  - If both are active, the owner that did not win the previous grant wins.
  - last_owner resets to CFG, so IRQ wins the first tie.
- IRQ owner: read of STATUS_ADDR (PWRITE=0, PWDATA=0).
  - At ACCESS completion with PSLVERR=0: pending <= PRDATA.
  - With PSLVERR=1: pending unchanged (stays 0) and status_err pulses for one cycle after completion.
  - A zero status read is legal; no events result.
- CFG owner:
  - cfg_done = (state==ACCESS && owner==CFG && PREADY), combinational.
  - cfg_rdata = PRDATA and cfg_err = PSLVERR, passed through in the same cycle.
- Event dispatch runs independently of the APB FSM, so config transfers proceed while events drain.
  - evt_valid = |pending.
  - evt_pin = index of the lowest set bit of pending.
  - On evt_valid && evt_ready, that bit clears.
- No new status read is issued while pending != 0. The GPIO interrupt stays asserted as backpressure, and events are never lost or overwritten.
- evt_pin is stable while evt_valid && !evt_ready.
- busy = (state != IDLE) || (pending != 0).

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - state IDLE, pending = 0, last_owner = CFG.
  - evt_valid = 0, evt_pin = 0, cfg_done = 0, status_err = 0, busy = 0.
- Reset mid-transfer: PSEL/PENABLE are 0 in the cycle after the reset edge, and pending is cleared. The aborted cfg transfer gets no cfg_done.
- APB transfer with PREADY=1 takes 2 cycles (SETUP, ACCESS). Each PREADY=0 cycle in ACCESS adds one cycle.
- IRQ latency with PREADY=1:
  - irq_i sampled high in IDLE at cycle 0.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - evt_valid high at cycle 3.
- The GPIO interrupt deasserts on the same edge that completes the status read. irq_i is therefore low in the following IDLE cycle, and no duplicate read is issued.
- Event throughput is one per cycle with evt_ready held high. A status with N bits set drains in N cycles.
- cfg_req sampled with cfg_done high is treated as a new request at the next IDLE.

## Test plan
- Reset: assert HRESET for 2 cycles during ACCESS -> next cycle PSEL=0, PENABLE=0, evt_valid=0, busy=0.
- Config write: cfg_req, cfg_addr='h008, cfg_wdata='hA5, cfg_write=1, PREADY=1 -> SETUP then ACCESS with PADDR='h008, PWDATA='hA5, PWRITE=1; cfg_done high on the 2nd cycle with cfg_err=0.
- IRQ dispatch:
  - irq_i=1, status PRDATA='h0000_0102, evt_ready=0 for 3 cycles, then 1 -> one read of 'h018 and evt_valid at cycle 3.
  - evt_pin=1 held stable through the stall, then evt_pin=8, then evt_valid=0.
  - No second status read while pending is nonzero, even with irq_i held high.
- Tie-break: irq_i and cfg_req both high right after reset -> IRQ read first, then cfg; on the next tie (pending drained) -> cfg first.
- Wait and error: PREADY=0 for 3 cycles, then 1 with PSLVERR=1 on a cfg read -> PENABLE held 4 cycles; cfg_done=1 and cfg_err=1 in the last cycle.
- Status read error: status read with PSLVERR=1 -> status_err pulses once and pending stays 0.

Source files
------------

// File: rtl/apb_gpio_irq_ctrl.sv
// apb_gpio_irq_ctrl
// APB master in front of the GPIO APB slave. The slave port is shared between a register
// configuration requester (cfg_*) and an interrupt service sequencer. On a GPIO interrupt
// the sequencer reads the status register, which clears the interrupt, and then streams
// each flagged pin index, lowest first, on a valid/ready event interface.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   irq_i                 GPIO interrupt level
//   cfg_req/addr/wdata/write, cfg_done/rdata/err   configuration transfer handshake
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR   APB master port
//   evt_valid/evt_pin/evt_ready   pin event stream
//   status_err            one-cycle pulse when the status read returns PSLVERR
//   busy                  APB transfer in flight or events still pending
module apb_gpio_irq_ctrl #(
   parameter int unsigned                APB_ADDR_WIDTH = 12,
   parameter logic [APB_ADDR_WIDTH-1:0]  STATUS_ADDR    = 'h018
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      irq_i,
   input  logic                      cfg_req,
   input  logic [APB_ADDR_WIDTH-1:0] cfg_addr,
   input  logic [31:0]               cfg_wdata,
   input  logic                      cfg_write,
   output logic                      cfg_done,
   output logic [31:0]               cfg_rdata,
   output logic                      cfg_err,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR,
   output logic                      evt_valid,
   output logic [4:0]                evt_pin,
   input  logic                      evt_ready,
   output logic                      status_err,
   output logic                      busy
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   localparam logic OwnCfg = 1'b0;
   localparam logic OwnIrq = 1'b1;

   state_e                    state_q, state_d;
   logic                      owner_q, owner_d;
   logic                      last_owner_q, last_owner_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic [31:0]               pending_q, pending_d;
   logic                      status_err_q, status_err_d;

   logic                      irq_req;
   logic                      grant_irq;
   logic                      xfer_done;
   logic                      evt_fire;
   logic [31:0]               pending_low;

   // A new status read is held off until every pending event has drained.
   assign irq_req     = irq_i && (pending_q == '0);
   assign xfer_done   = (state_q == StAccess) && PREADY;
   assign evt_fire    = evt_valid && evt_ready;
   // Isolates the lowest set bit of pending.
   assign pending_low = pending_q & (~pending_q + 32'd1);

   // State register and datapath flops.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= StIdle;
         owner_q      <= OwnCfg;
         last_owner_q <= OwnCfg;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pwrite_q     <= 1'b0;
         pending_q    <= '0;
         status_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pwrite_q     <= pwrite_d;
         pending_q    <= pending_d;
         status_err_q <= status_err_d;
      end
   end

   // Next-state: arbitration in IDLE, APB phase sequencing.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pwrite_d     = pwrite_q;
      grant_irq    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (irq_req || cfg_req) begin
               // On a tie, the requester that lost the previous grant wins.
               grant_irq    = irq_req && (!cfg_req || (last_owner_q == OwnCfg));
               state_d      = StSetup;
               owner_d      = grant_irq ? OwnIrq : OwnCfg;
               last_owner_d = grant_irq ? OwnIrq : OwnCfg;
               if (grant_irq) begin
                  paddr_d  = STATUS_ADDR;
                  pwdata_d = '0;
                  pwrite_d = 1'b0;
               end else begin
                  paddr_d  = cfg_addr;
                  pwdata_d = cfg_wdata;
                  pwrite_d = cfg_write;
               end
            end
         end
         StSetup:  state_d = StAccess;
         StAccess: if (PREADY) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Pending event set: loaded by a good status read, drained one bit per accepted event.
   // A status read only starts with pending empty, so load and drain never overlap.
   always_comb begin
      pending_d    = pending_q;
      status_err_d = 1'b0;
      if (evt_fire) begin
         pending_d = pending_q & ~pending_low;
      end
      if (xfer_done && (owner_q == OwnIrq)) begin
         if (PSLVERR) begin
            status_err_d = 1'b1;
         end else begin
            pending_d = PRDATA;
         end
      end
   end

   // Lowest-index priority encoder; the last assignment in the downward loop wins.
   always_comb begin
      evt_pin = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (pending_q[i]) evt_pin = 5'(i);
      end
   end

   // Outputs.
   always_comb begin
      PSEL       = (state_q != StIdle);
      PENABLE    = (state_q == StAccess);
      PADDR      = paddr_q;
      PWDATA     = pwdata_q;
      PWRITE     = pwrite_q;
      cfg_done   = xfer_done && (owner_q == OwnCfg);
      cfg_rdata  = PRDATA;
      cfg_err    = PSLVERR;
      evt_valid  = |pending_q;
      status_err = status_err_q;
      busy       = (state_q != StIdle) || (pending_q != '0);
   end

endmodule

// File: tb/tb_apb_gpio_irq_ctrl.sv
// Self-checking bench for apb_gpio_irq_ctrl. Expected APB transfers, cfg completions and
// pin events are queued by the stimulus; a monitor pops and compares them as the DUT
// presents each one.
module tb_apb_gpio_irq_ctrl;

   logic        HCLK, HRESET, irq_i, cfg_req, cfg_write, cfg_done, cfg_err;
   logic [11:0] cfg_addr, PADDR;
   logic [31:0] cfg_wdata, cfg_rdata, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic        evt_valid, evt_ready, status_err, busy;
   logic [4:0]  evt_pin;

   // APB slave model state
   logic [31:0] status_val, cfg_rval;
   logic        slv_err;
   int          wait_n, acc_cnt;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [7:0]  len;
   } apb_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } cfg_t;

   apb_t       apb_q[$];
   cfg_t       cfg_q[$];
   logic [4:0] evt_q[$];
   int         checks, errors, serr_seen, serr_exp;

   apb_gpio_irq_ctrl #(.APB_ADDR_WIDTH(12), .STATUS_ADDR(12'h018)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .irq_i(irq_i),
      .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_write(cfg_write),
      .cfg_done(cfg_done), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .evt_valid(evt_valid), .evt_pin(evt_pin), .evt_ready(evt_ready),
      .status_err(status_err), .busy(busy)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Slave inserts wait_n wait states in ACCESS.
   assign PREADY  = (acc_cnt >= wait_n);
   assign PRDATA  = (PADDR == 12'h018) ? status_val : cfg_rval;
   assign PSLVERR = slv_err;

   always @(posedge HCLK) begin
      acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push_apb(input logic [11:0] a, input logic [31:0] d, input logic w,
                           input logic [7:0] l);
      apb_t t;
      t.addr = a; t.wdata = d; t.wr = w; t.len = l;
      apb_q.push_back(t);
   endtask

   task automatic push_cfg(input logic [31:0] d, input logic e);
      cfg_t t;
      t.rdata = d; t.err = e;
      cfg_q.push_back(t);
   endtask

   // Raise the requested lines and drop each one right after its transfer completes,
   // as the GPIO does with its interrupt when the status read finishes.
   task automatic run(input bit do_irq, input bit do_cfg);
      bit got_i, got_c, sdone, cdone;
      irq_i   = do_irq;
      cfg_req = do_cfg;
      got_i   = !do_irq;
      got_c   = !do_cfg;
      for (int n = 0; n < 60 && !(got_i && got_c); n++) begin
         @(negedge HCLK);
         sdone = PSEL && PENABLE && PREADY && !PWRITE && (PADDR == 12'h018);
         cdone = cfg_done;
         tick();
         if (sdone && do_irq) begin irq_i = 1'b0; got_i = 1'b1; end
         if (cdone && do_cfg) begin cfg_req = 1'b0; got_c = 1'b1; end
      end
      chk("run_timeout", {30'd0, got_i, got_c}, 32'd3);
      irq_i   = 1'b0;
      cfg_req = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; serr_seen = 0; serr_exp = 0;
      HRESET = 1'b1; irq_i = 1'b0; cfg_req = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      cfg_write = 1'b0; evt_ready = 1'b0; status_val = '0; cfg_rval = '0; slv_err = 1'b0;
      wait_n = 0;

      fork
         begin : monitor
            int   en_cnt;
            bit   prev_stall;
            logic [4:0] prev_pin;
            apb_t a;
            cfg_t c;
            logic [4:0] p;
            en_cnt = 0; prev_stall = 0; prev_pin = '0;
            forever begin
               @(negedge HCLK);
               if (HRESET) begin
                  en_cnt = 0;
                  prev_stall = 0;
               end else begin
                  if (PSEL && PENABLE) en_cnt++;
                  if (PSEL && PENABLE && PREADY) begin
                     if (apb_q.size() == 0) begin
                        chk("apb_unexpected", {20'd0, PADDR}, 32'hFFFF_FFFF);
                     end else begin
                        a = apb_q.pop_front();
                        chk("apb_addr", {20'd0, PADDR}, {20'd0, a.addr});
                        chk("apb_wdata", PWDATA, a.wdata);
                        chk("apb_write", {31'd0, PWRITE}, {31'd0, a.wr});
                        chk("apb_enable_len", en_cnt, {24'd0, a.len});
                     end
                     en_cnt = 0;
                  end
                  if (cfg_done) begin
                     if (cfg_q.size() == 0) begin
                        chk("cfg_done_unexpected", {31'd0, cfg_done}, 32'd0);
                     end else begin
                        c = cfg_q.pop_front();
                        chk("cfg_rdata", cfg_rdata, c.rdata);
                        chk("cfg_err", {31'd0, cfg_err}, {31'd0, c.err});
                     end
                  end
                  if (prev_stall) begin
                     chk("evt_hold_valid", {31'd0, evt_valid}, 32'd1);
                     chk("evt_hold_pin", {27'd0, evt_pin}, {27'd0, prev_pin});
                  end
                  if (evt_valid && evt_ready) begin
                     if (evt_q.size() == 0) begin
                        chk("evt_unexpected", {27'd0, evt_pin}, 32'hFFFF_FFFF);
                     end else begin
                        p = evt_q.pop_front();
                        chk("evt_pin", {27'd0, evt_pin}, {27'd0, p});
                     end
                  end
                  prev_stall = evt_valid && !evt_ready;
                  prev_pin   = evt_pin;
                  if (status_err) serr_seen++;
               end
            end
         end
         begin : watchdog
            #200000;
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset values
      tick(); tick();
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("rst_psel", {31'd0, PSEL}, 32'd0);
      chk("rst_penable", {31'd0, PENABLE}, 32'd0);
      chk("rst_paddr", {20'd0, PADDR}, 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
      chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
      chk("rst_evt_pin", {27'd0, evt_pin}, 32'd0);
      chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
      chk("rst_status_err", {31'd0, status_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // First tie after reset: IRQ wins, then cfg
      status_val = 32'h1; evt_ready = 1'b1;
      cfg_addr = 12'h010; cfg_wdata = 32'h0F0F; cfg_write = 1'b1;
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      push_apb(12'h010, 32'h0F0F, 1'b1, 8'd1);
      push_cfg(32'h0, 1'b0);
      evt_q.push_back(5'd0);
      run(1'b1, 1'b1);
      tick(); tick();

      // IRQ dispatch with stall and irq re-raised while events are pending
      status_val = 32'h0000_0102; evt_ready = 1'b0;
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      evt_q.push_back(5'd1);
      evt_q.push_back(5'd8);
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      irq_i = 1'b1;
      @(negedge HCLK);
      chk("irq_c0_psel", {31'd0, PSEL}, 32'd0);
      tick(); @(negedge HCLK);
      chk("irq_c1_psel", {31'd0, PSEL}, 32'd1);
      chk("irq_c1_penable", {31'd0, PENABLE}, 32'd0);
      chk("irq_c1_paddr", {20'd0, PADDR}, 32'h018);
      tick(); @(negedge HCLK);
      chk("irq_c2_penable", {31'd0, PENABLE}, 32'd1);
      chk("irq_c2_evt_valid", {31'd0, evt_valid}, 32'd0);
      tick(); irq_i = 1'b0; status_val = 32'h0;
      @(negedge HCLK);
      chk("irq_c3_evt_valid", {31'd0, evt_valid}, 32'd1);
      chk("irq_c3_evt_pin", {27'd0, evt_pin}, 32'd1);
      chk("irq_c3_psel", {31'd0, PSEL}, 32'd0);
      tick(); irq_i = 1'b1;
      @(negedge HCLK);
      chk("irq_c4_psel", {31'd0, PSEL}, 32'd0);
      tick(); @(negedge HCLK);
      chk("irq_c5_psel", {31'd0, PSEL}, 32'd0);
      chk("irq_c5_busy", {31'd0, busy}, 32'd1);
      tick(); evt_ready = 1'b1;
      @(negedge HCLK);
      chk("irq_c6_evt_pin", {27'd0, evt_pin}, 32'd1);
      tick(); @(negedge HCLK);
      chk("irq_c7_evt_pin", {27'd0, evt_pin}, 32'd8);
      chk("irq_c7_psel", {31'd0, PSEL}, 32'd0);
      tick(); @(negedge HCLK);
      chk("irq_c8_evt_valid", {31'd0, evt_valid}, 32'd0);
      // Drained with irq still high: a fresh status read (value zero, no events)
      run(1'b1, 1'b0);
      tick();

      // Second tie, IRQ won last: cfg first
      status_val = 32'h8000_0000; cfg_addr = 12'h004; cfg_wdata = 32'h1234_5678;
      cfg_write = 1'b1;
      push_apb(12'h004, 32'h1234_5678, 1'b1, 8'd1);
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      push_cfg(32'h0, 1'b0);
      evt_q.push_back(5'd31);
      run(1'b1, 1'b1);
      tick(); tick();

      // Config write with direct phase checks
      cfg_addr = 12'h008; cfg_wdata = 32'hA5; cfg_write = 1'b1;
      push_apb(12'h008, 32'hA5, 1'b1, 8'd1);
      push_cfg(32'h0, 1'b0);
      cfg_req = 1'b1;
      tick(); @(negedge HCLK);
      chk("cw_setup_psel", {31'd0, PSEL}, 32'd1);
      chk("cw_setup_penable", {31'd0, PENABLE}, 32'd0);
      chk("cw_setup_paddr", {20'd0, PADDR}, 32'h008);
      chk("cw_setup_pwdata", PWDATA, 32'hA5);
      chk("cw_setup_pwrite", {31'd0, PWRITE}, 32'd1);
      chk("cw_setup_done", {31'd0, cfg_done}, 32'd0);
      tick(); @(negedge HCLK);
      chk("cw_access_penable", {31'd0, PENABLE}, 32'd1);
      chk("cw_access_done", {31'd0, cfg_done}, 32'd1);
      chk("cw_access_err", {31'd0, cfg_err}, 32'd0);
      tick(); cfg_req = 1'b0;
      @(negedge HCLK);
      chk("cw_idle_psel", {31'd0, PSEL}, 32'd0);
      tick();

      // Wait states and error on cfg read
      cfg_addr = 12'h00C; cfg_wdata = 32'h0; cfg_write = 1'b0;
      wait_n = 3; slv_err = 1'b1; cfg_rval = 32'hDEAD_BEEF;
      push_apb(12'h00C, 32'h0, 1'b0, 8'd4);
      push_cfg(32'hDEAD_BEEF, 1'b1);
      run(1'b0, 1'b1);
      wait_n = 0; slv_err = 1'b0; cfg_rval = 32'h0;
      tick();

      // Status read error
      slv_err = 1'b1; status_val = 32'h55;
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      serr_exp++;
      run(1'b1, 1'b0);
      slv_err = 1'b0;
      @(negedge HCLK);
      chk("serr_pulse", {31'd0, status_err}, 32'd1);
      chk("serr_no_evt", {31'd0, evt_valid}, 32'd0);
      tick(); @(negedge HCLK);
      chk("serr_pulse_end", {31'd0, status_err}, 32'd0);
      chk("serr_busy", {31'd0, busy}, 32'd0);
      tick();

      // Reset mid-transfer while events are pending
      status_val = 32'h3; evt_ready = 1'b0;
      push_apb(12'h018, 32'h0, 1'b0, 8'd1);
      run(1'b1, 1'b0);
      @(negedge HCLK);
      chk("mr_evt_valid", {31'd0, evt_valid}, 32'd1);
      chk("mr_evt_pin", {27'd0, evt_pin}, 32'd0);
      cfg_addr = 12'h014; cfg_wdata = 32'h77; cfg_write = 1'b1; wait_n = 10;
      cfg_req = 1'b1;
      tick(); tick(); @(negedge HCLK);
      chk("mr_in_access", {31'd0, PENABLE}, 32'd1);
      chk("mr_busy", {31'd0, busy}, 32'd1);
      tick(); HRESET = 1'b1; cfg_req = 1'b0;
      tick();
      tick(); HRESET = 1'b0; wait_n = 0;
      @(negedge HCLK);
      chk("mr_psel", {31'd0, PSEL}, 32'd0);
      chk("mr_penable", {31'd0, PENABLE}, 32'd0);
      chk("mr_evt_valid_clr", {31'd0, evt_valid}, 32'd0);
      chk("mr_busy_clr", {31'd0, busy}, 32'd0);
      chk("mr_cfg_done", {31'd0, cfg_done}, 32'd0);
      tick(); tick(); tick();

      // Everything expected was seen
      chk("apb_q_left", apb_q.size(), 32'd0);
      chk("cfg_q_left", cfg_q.size(), 32'd0);
      chk("evt_q_left", evt_q.size(), 32'd0);
      chk("status_err_pulses", serr_seen, serr_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
